albatea_nucleo_param: RTL

Parametrised successor of the AlbaTEA game top. Control FSM and datapath merge into one core for an NxN LED-matrix "toggle puzzle" with a configurable level count, a per-level time limit and a lives counter. The core drives a row-scanned matrix (one row active at a time). Level targets come from an external pattern ROM, indexed by the current level. The 7-segment decoders stay outside the core and are fed from the db_* outputs.

---
 rtl/albatea_pkg.sv | 39 +++
 rtl/albatea_nucleo_param_if.sv | 33 +++
 rtl/varredura_matriz.sv | 54 +++++
 rtl/albatea_nucleo_param.sv | 133 +++++++++++++
 4 files changed

// File: rtl/albatea_pkg.sv
// Shared types, widths and helpers for the parametrised AlbaTEA toggle-puzzle core.
package albatea_pkg;

  localparam int unsigned N_MAX     = 16;
  localparam int unsigned MAT_MAX   = N_MAX * N_MAX;
  localparam int unsigned IDX_MAX_W = $clog2(MAT_MAX);
  localparam int unsigned EST_W     = 4;
  localparam int unsigned VIDAS_W   = 4;

  typedef enum logic [EST_W-1:0] {
    INICIAL = 4'd0,
    CARREGA = 4'd1,
    JOGANDO = 4'd2,
    PASSOU  = 4'd3,
    FALHOU  = 4'd4,
    GANHOU  = 4'd5,
    PERDEU  = 4'd6
  } estado_t;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned largura(input int unsigned valor);
    return (valor > 1) ? $clog2(valor) : 1;
  endfunction

  // Row i and column i of an n x n matrix; the shared cell (i,i) is set as well.
  function automatic logic [MAT_MAX-1:0] mascara_cruz(input int unsigned i, input int unsigned n);
    logic [MAT_MAX-1:0] mascara;
    mascara = '0;
    for (int unsigned r = 0; r < N_MAX; r++) begin
      for (int unsigned c = 0; c < N_MAX; c++) begin
        if (r < n && c < n && (r == i || c == i)) begin
          mascara[IDX_MAX_W'(r * n + c)] = 1'b1;
        end
      end
    end
    return mascara;
  endfunction

endpackage

// File: rtl/albatea_nucleo_param_if.sv
// Player controls, pattern ROM data and display/status outputs of the puzzle core.
interface albatea_nucleo_param_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned NUM_NIVEIS = 8
);
  import albatea_pkg::*;

  localparam int unsigned NIVEL_W = largura(NUM_NIVEIS);

  logic                 jogar;
  logic                 rst_niv;
  logic [N-1:0]         botoes;
  logic [N*N-1:0]       padrao_alvo;
  logic [N-1:0]         linhas;
  logic [N-1:0]         colunas;
  logic [NIVEL_W-1:0]   nivel;
  logic                 passou_nivel;
  logic                 ganhou;
  logic                 perdeu;
  logic [EST_W-1:0]     db_estado;
  logic [VIDAS_W-1:0]   db_vidas;

  modport master (
    output jogar, rst_niv, botoes, padrao_alvo,
    input  linhas, colunas, nivel, passou_nivel, ganhou, perdeu, db_estado, db_vidas
  );

  modport slave (
    input  jogar, rst_niv, botoes, padrao_alvo,
    output linhas, colunas, nivel, passou_nivel, ganhou, perdeu, db_estado, db_vidas
  );

endinterface

// File: rtl/varredura_matriz.sv
// Row scanner: one row active at a time, each held for T_VARRE cycles.
module varredura_matriz
  import albatea_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned T_VARRE = 5_000
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [N*N-1:0] matriz,
  output logic [N-1:0]   linhas,
  output logic [N-1:0]   colunas
);

  localparam int unsigned CNT_W = largura(T_VARRE);
  localparam int unsigned ROW_W = largura(N);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] linha, linha_n;
  logic [N-1:0]     linhas_n, colunas_n;

  // Outputs are computed from the next row so linhas and colunas switch together.
  always_comb begin
    cnt_n     = cnt + CNT_W'(1);
    linha_n   = linha;
    linhas_n  = '0;
    colunas_n = '0;
    if (cnt == CNT_W'(T_VARRE - 1)) begin
      cnt_n   = '0;
      linha_n = (linha == ROW_W'(N - 1)) ? '0 : linha + ROW_W'(1);
    end
    for (int unsigned r = 0; r < N; r++) begin
      if (linha_n == ROW_W'(r)) begin
        linhas_n[r] = 1'b1;
        colunas_n   = matriz[r*N +: N];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      linha   <= '0;
      linhas  <= N'(1);
      colunas <= '0;
    end else begin
      cnt     <= cnt_n;
      linha   <= linha_n;
      linhas  <= linhas_n;
      colunas <= colunas_n;
    end
  end

endmodule

// File: rtl/albatea_nucleo_param.sv
// Toggle-puzzle game core: level/lives/timer FSM, NxN matrix register and row scanner.
module albatea_nucleo_param
  import albatea_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned NUM_NIVEIS = 8,
  parameter int unsigned T_LIMITE   = 50_000_000,
  parameter int unsigned T_VARRE    = 5_000,
  parameter int unsigned VIDAS      = 3
) (
  input logic                   clock,
  input logic                   reset_n,
  albatea_nucleo_param_if.slave bus
);

  localparam int unsigned MAT_W   = N * N;
  localparam int unsigned NIVEL_W = largura(NUM_NIVEIS);
  localparam int unsigned TIMER_W = largura(T_LIMITE);

  estado_t              estado, estado_n;
  logic [MAT_W-1:0]     m, m_n, alvo, alvo_n, alterna;
  logic [NIVEL_W-1:0]   nivel, nivel_n;
  logic [VIDAS_W-1:0]   vidas, vidas_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [N-1:0]         botoes_q, borda;
  logic                 passou_q, ganhou_q, perdeu_q;

  assign borda = bus.botoes & ~botoes_q;

  // Simultaneous presses combine by XOR of their cross masks.
  always_comb begin
    alterna = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (borda[i]) alterna = alterna ^ MAT_W'(mascara_cruz(i, N));
    end
  end

  always_comb begin
    estado_n = estado;
    m_n      = m;
    alvo_n   = alvo;
    nivel_n  = nivel;
    vidas_n  = vidas;
    timer_n  = timer;
    case (estado)
      INICIAL, GANHOU, PERDEU: begin
        if (bus.jogar) begin
          nivel_n  = '0;
          vidas_n  = VIDAS_W'(VIDAS);
          estado_n = CARREGA;
        end
      end
      CARREGA: begin
        alvo_n   = bus.padrao_alvo;
        m_n      = '0;
        timer_n  = '0;
        estado_n = JOGANDO;
      end
      JOGANDO: begin
        // A solved board wins over a timeout, which wins over a level restart.
        if (m == alvo) begin
          estado_n = PASSOU;
        end else if (timer == TIMER_W'(T_LIMITE - 1)) begin
          estado_n = FALHOU;
        end else if (bus.rst_niv) begin
          m_n     = '0;
          timer_n = '0;
        end else begin
          m_n     = m ^ alterna;
          timer_n = timer + TIMER_W'(1);
        end
      end
      PASSOU: begin
        if (nivel == NIVEL_W'(NUM_NIVEIS - 1)) begin
          estado_n = GANHOU;
        end else begin
          nivel_n  = nivel + NIVEL_W'(1);
          estado_n = CARREGA;
        end
      end
      FALHOU: begin
        if (vidas != '0) vidas_n = vidas - VIDAS_W'(1);
        estado_n = (vidas <= VIDAS_W'(1)) ? PERDEU : CARREGA;
      end
      default: estado_n = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= INICIAL;
      m        <= '0;
      alvo     <= '0;
      nivel    <= '0;
      vidas    <= VIDAS_W'(VIDAS);
      timer    <= '0;
      botoes_q <= '0;
      passou_q <= 1'b0;
      ganhou_q <= 1'b0;
      perdeu_q <= 1'b0;
    end else begin
      estado   <= estado_n;
      m        <= m_n;
      alvo     <= alvo_n;
      nivel    <= nivel_n;
      vidas    <= vidas_n;
      timer    <= timer_n;
      botoes_q <= bus.botoes;
      passou_q <= (estado_n == PASSOU);
      ganhou_q <= (estado_n == GANHOU);
      perdeu_q <= (estado_n == PERDEU);
    end
  end

  assign bus.nivel        = nivel;
  assign bus.db_estado    = estado;
  assign bus.db_vidas     = vidas;
  assign bus.passou_nivel = passou_q;
  assign bus.ganhou       = ganhou_q;
  assign bus.perdeu       = perdeu_q;

  varredura_matriz #(
    .N       (N),
    .T_VARRE (T_VARRE)
  ) u_varredura (
    .clock   (clock),
    .reset_n (reset_n),
    .matriz  (m),
    .linhas  (bus.linhas),
    .colunas (bus.colunas)
  );

endmodule
